// File: rtl/mc_ctrl_if.sv
// Control-unit bus: IR fields and ALU flag in, datapath enables and debug state out.
// slave = the control unit, master = the datapath side driving the IR fields.
interface mc_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        IRWre;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic [2:0]  ALUOp;
  logic        ExtSel;
  logic [1:0]  RegDst;
  logic        WrRegDSrc;
  logic        RegWre;
  logic        mRD;
  logic        mWR;
  logic        DBDataSrc;
  logic [3:0]  state;
  logic [31:0] retire_cnt;

  modport master (
    output opcode, funct, zero,
    input  PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst,
           WrRegDSrc, RegWre, mRD, mWR, DBDataSrc, state, retire_cnt
  );

  modport slave (
    input  opcode, funct, zero,
    output PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst,
           WrRegDSrc, RegWre, mRD, mWR, DBDataSrc, state, retire_cnt
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control FSM: sequences IF/ID/EXE/MEM/WB, drives PC
// update (one PCWre pulse per retired instruction) and datapath enables.
module mc_control_unit #(
  parameter logic [5:0] HALT_OP     = 6'b111111,
  parameter bit         NOP_ADVANCE = 1'b1
) (
  input  logic     CLK,
  input  logic     RST,
  mc_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retire_cnt;

  logic w_rtype, w_r_alu, w_jr, w_j, w_jal, w_beq, w_bne, w_lw, w_sw;
  logic w_addi, w_ori, w_halt, w_alu_cls;

  assign w_rtype   = (bus.opcode == OP_RTYPE);
  assign w_r_alu   = w_rtype & ((bus.funct == FN_ADD) | (bus.funct == FN_SUB) |
                                (bus.funct == FN_AND) | (bus.funct == FN_OR)  |
                                (bus.funct == FN_SLT) | (bus.funct == FN_SLL));
  assign w_jr      = w_rtype & (bus.funct == FN_JR);
  assign w_j       = (bus.opcode == OP_J);
  assign w_jal     = (bus.opcode == OP_JAL);
  assign w_beq     = (bus.opcode == OP_BEQ);
  assign w_bne     = (bus.opcode == OP_BNE);
  assign w_lw      = (bus.opcode == OP_LW);
  assign w_sw      = (bus.opcode == OP_SW);
  assign w_addi    = (bus.opcode == OP_ADDI);
  assign w_ori     = (bus.opcode == OP_ORI);
  assign w_halt    = (bus.opcode == HALT_OP);
  assign w_alu_cls = w_r_alu | w_addi | w_ori;

  // ALU-class controls follow the IR; gated to the ID..last-state window below
  logic [2:0] w_aluop;
  logic       w_srca, w_srcb, w_ext;

  always_comb begin
    w_aluop = 3'b000;
    w_srca  = 1'b0;
    w_srcb  = 1'b0;
    w_ext   = 1'b0;
    if (w_r_alu) begin
      case (bus.funct)
        FN_SUB:  w_aluop = 3'b001;
        FN_AND:  w_aluop = 3'b010;
        FN_OR:   w_aluop = 3'b011;
        FN_SLT:  w_aluop = 3'b100;
        FN_SLL: begin
          w_aluop = 3'b101;
          w_srca  = 1'b1;
        end
        default: w_aluop = 3'b000;
      endcase
    end else if (w_addi) begin
      w_srcb = 1'b1;
      w_ext  = 1'b1;
    end else if (w_ori) begin
      w_aluop = 3'b011;
      w_srcb  = 1'b1;
    end else if (w_beq | w_bne) begin
      w_aluop = 3'b001;
      w_ext   = 1'b1;
    end else if (w_lw | w_sw) begin
      w_srcb = 1'b1;
      w_ext  = 1'b1;
    end
  end

  logic       w_pcwre, w_irwre, w_regwre, w_mrd, w_mwr, w_wrsrc, w_dbsrc, w_alu_en;
  logic [1:0] w_pcsrc, w_regdst;

  always_comb begin
    w_next   = r_state;
    w_pcwre  = 1'b0;
    w_pcsrc  = 2'b00;
    w_irwre  = 1'b0;
    w_regwre = 1'b0;
    w_regdst = 2'b00;
    w_wrsrc  = 1'b0;
    w_mrd    = 1'b0;
    w_mwr    = 1'b0;
    w_dbsrc  = 1'b0;
    w_alu_en = 1'b0;
    case (r_state)
      S_IF: begin
        w_irwre = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        w_alu_en = 1'b1;
        if (w_halt) begin
          w_next = S_HALT;
        end else if (w_j) begin
          w_pcsrc = 2'b11;
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end else if (w_jal) begin
          w_pcsrc  = 2'b11;
          w_pcwre  = 1'b1;
          w_regwre = 1'b1;
          w_next   = S_IF;
        end else if (w_jr) begin
          w_pcsrc = 2'b10;
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end else if (w_beq | w_bne) begin
          w_next = S_EXE_BR;
        end else if (w_lw | w_sw) begin
          w_next = S_EXE_LS;
        end else if (w_alu_cls) begin
          w_next = S_EXE_AL;
        end else if (NOP_ADVANCE) begin
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end else begin
          w_next = S_HALT;
        end
      end
      S_EXE_AL: begin
        w_alu_en = 1'b1;
        w_next   = S_WB_AL;
      end
      S_WB_AL: begin
        w_alu_en = 1'b1;
        w_regwre = 1'b1;
        w_regdst = w_rtype ? 2'b10 : 2'b01;
        w_wrsrc  = 1'b1;
        w_pcwre  = 1'b1;
        w_next   = S_IF;
      end
      S_EXE_BR: begin
        w_alu_en = 1'b1;
        w_pcwre  = 1'b1;
        w_pcsrc  = ((w_beq & bus.zero) | (w_bne & ~bus.zero)) ? 2'b01 : 2'b00;
        w_next   = S_IF;
      end
      S_EXE_LS: begin
        w_alu_en = 1'b1;
        w_next   = S_MEM;
      end
      S_MEM: begin
        w_alu_en = 1'b1;
        if (w_sw) begin
          w_mwr   = 1'b1;
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end else begin
          w_mrd  = 1'b1;
          w_next = S_WB_LD;
        end
      end
      S_WB_LD: begin
        w_alu_en = 1'b1;
        w_mrd    = 1'b1;
        w_dbsrc  = 1'b1;
        w_wrsrc  = 1'b1;
        w_regdst = 2'b01;
        w_regwre = 1'b1;
        w_pcwre  = 1'b1;
        w_next   = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_IF;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_pcwre) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  // Reset masks every output so nothing writes during an abandoned instruction
  assign bus.PCWre      = RST & w_pcwre;
  assign bus.PCSrc      = RST ? w_pcsrc : 2'b00;
  assign bus.IRWre      = RST & w_irwre;
  assign bus.RegWre     = RST & w_regwre;
  assign bus.RegDst     = RST ? w_regdst : 2'b00;
  assign bus.WrRegDSrc  = RST & w_wrsrc;
  assign bus.mRD        = RST & w_mrd;
  assign bus.mWR        = RST & w_mwr;
  assign bus.DBDataSrc  = RST & w_dbsrc;
  assign bus.ALUOp      = (RST & w_alu_en) ? w_aluop : 3'b000;
  assign bus.ALUSrcA    = RST & w_alu_en & w_srca;
  assign bus.ALUSrcB    = RST & w_alu_en & w_srcb;
  assign bus.ExtSel     = RST & w_alu_en & w_ext;
  assign bus.state      = RST ? r_state : 4'd0;
  assign bus.retire_cnt = RST ? r_retire_cnt : 32'd0;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction-stream bench for mc_control_unit against a per-instruction
// step model derived from the instruction-class sequences.
module tb_mc_control_unit;

  logic clk;
  logic rst;
  mc_ctrl_if bus ();

  mc_control_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] st;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       regwre;
    logic       mrd;
    logic       mwr;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       dbsrc;
    logic [2:0] aluop;
    logic       srca;
    logic       srcb;
    logic       ext;
  } obs_t;

  localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_BEQ = 3, K_BNE = 4, K_LW = 5;
  localparam int K_SW = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10, K_HALT = 11;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state;       o.pcwre = bus.PCWre;   o.pcsrc = bus.PCSrc;
    o.irwre = bus.IRWre;    o.regwre = bus.RegWre; o.mrd = bus.mRD;
    o.mwr = bus.mWR;        o.regdst = bus.RegDst; o.wrsrc = bus.WrRegDSrc;
    o.dbsrc = bus.DBDataSrc; o.aluop = bus.ALUOp;  o.srca = bus.ALUSrcA;
    o.srcb = bus.ALUSrcB;   o.ext = bus.ExtSel;
    return o;
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000})
          return K_R;
        return K_NOP;
      end
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b001000: return K_ADDI;
      6'b001101: return K_ORI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b111111: return K_HALT;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic int len_of(input int kind);
    case (kind)
      K_R, K_ADDI, K_ORI, K_SW: return 4;
      K_BEQ, K_BNE:             return 3;
      K_LW:                     return 5;
      default:                  return 2;
    endcase
  endfunction

  // IF,ID, then ALU 2,3 / branch 4 / load-store 5,6,7
  function automatic int st_at(input int kind, input int k);
    if (k < 2) return k;
    if (kind inside {K_BEQ, K_BNE}) return 4;
    if (kind inside {K_LW, K_SW}) return k + 3;
    return k;
  endfunction

  task automatic expect_step(input int kind, input logic [5:0] fn, input logic z, input int k,
                             output obs_t e, output obs_t m);
    bit last;
    last = (k == len_of(kind) - 1);
    e = '0;
    m = '1;
    e.st    = 4'(st_at(kind, k));
    e.irwre = (k == 0);
    e.pcwre = last;
    m.pcsrc = '0;
    if (last) begin
      m.pcsrc = '1;
      case (kind)
        K_J, K_JAL: e.pcsrc = 2'b11;
        K_JR:       e.pcsrc = 2'b10;
        K_BEQ:      e.pcsrc = z ? 2'b01 : 2'b00;
        K_BNE:      e.pcsrc = z ? 2'b00 : 2'b01;
        default:    e.pcsrc = 2'b00;
      endcase
    end
    e.regwre = last && (kind inside {K_R, K_ADDI, K_ORI, K_LW, K_JAL});
    m.regdst = '0;
    m.wrsrc  = 1'b0;
    if (e.regwre) begin
      m.regdst = '1;
      m.wrsrc  = 1'b1;
      e.regdst = (kind == K_R) ? 2'b10 : (kind == K_JAL) ? 2'b00 : 2'b01;
      e.wrsrc  = (kind != K_JAL);
    end
    m.dbsrc = last && (kind inside {K_R, K_ADDI, K_ORI, K_LW});
    e.dbsrc = (kind == K_LW);
    e.mrd   = (kind == K_LW) && (k >= 3);
    e.mwr   = (kind == K_SW) && (k == 3);
    if (k == 0 || (kind inside {K_J, K_JAL, K_JR, K_NOP})) begin
      m.aluop = '0; m.srca = 1'b0; m.srcb = 1'b0; m.ext = 1'b0;
    end else begin
      case (kind)
        K_R: begin
          m.ext = 1'b0;
          case (fn)
            6'b100010: e.aluop = 3'd1;
            6'b100100: e.aluop = 3'd2;
            6'b100101: e.aluop = 3'd3;
            6'b101010: e.aluop = 3'd4;
            6'b000000: begin e.aluop = 3'd5; e.srca = 1'b1; end
            default:   e.aluop = 3'd0;
          endcase
        end
        K_ADDI:       begin e.aluop = 3'd0; e.srcb = 1'b1; e.ext = 1'b1; end
        K_ORI:        begin e.aluop = 3'd3; e.srcb = 1'b1; e.ext = 1'b0; end
        K_BEQ, K_BNE: begin e.aluop = 3'd1; e.ext = 1'b1; end
        default:      begin e.aluop = 3'd0; e.srcb = 1'b1; e.ext = 1'b1; end
      endcase
    end
  endtask

  task automatic check_cycle(input string tag, input obs_t e, input obs_t m);
    obs_t o;
    o = sample();
    chk(tag, 32'(o & m), 32'(e & m));
    chk({tag, "_cnt"}, bus.retire_cnt, exp_cnt);
  endtask

  // Runs one instruction starting in IF; abort_at >= 0 pulls RST low in that step
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int abort_at);
    int   kind;
    obs_t e, m;
    kind = kind_of(op, fn);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    for (int k = 0; k < len_of(kind); k++) begin
      if (k == abort_at) begin
        rst     = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check_cycle({tag, "_rst"}, '0, '1);
        @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      expect_step(kind, fn, z, k, e, m);
      @(negedge clk);
      check_cycle($sformatf("%s_s%0d", tag, k), e, m);
      @(posedge clk);
      if (k == len_of(kind) - 1) exp_cnt++;
      #1;
    end
  endtask

  task automatic run_halt(input int cycles);
    obs_t e, m;
    bus.opcode = 6'b111111;
    bus.funct  = 6'($urandom);
    for (int k = 0; k < cycles + 2; k++) begin
      e = '0;
      m = '1;
      m.pcsrc = '0; m.regdst = '0; m.wrsrc = 1'b0; m.dbsrc = 1'b0;
      m.aluop = '0; m.srca = 1'b0; m.srcb = 1'b0; m.ext = 1'b0;
      e.st    = (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : 4'd8;
      e.irwre = (k == 0);
      @(negedge clk);
      check_cycle($sformatf("halt_c%0d", k), e, m);
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check_cycle("halt_rst", '0, '1);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  logic [5:0] alu_fn [6];
  logic [5:0] op, fn;
  int         sel;

  initial begin
    alu_fn[0] = 6'b100000; alu_fn[1] = 6'b100010; alu_fn[2] = 6'b100100;
    alu_fn[3] = 6'b100101; alu_fn[4] = 6'b101010; alu_fn[5] = 6'b000000;
    rst = 1'b0;
    bus.opcode = '0;
    bus.funct  = '0;
    bus.zero   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle("reset", '0, '1);
    @(posedge clk);
    #1 rst = 1'b1;

    run_instr("add",    6'b000000, 6'b100000, 1'b0, -1);
    run_instr("beq_z1", 6'b000100, 6'd0, 1'b1, -1);
    run_instr("beq_z0", 6'b000100, 6'd0, 1'b0, -1);
    run_instr("bne_z1", 6'b000101, 6'd0, 1'b1, -1);
    run_instr("bne_z0", 6'b000101, 6'd0, 1'b0, -1);
    run_instr("lw",     6'b100011, 6'd7, 1'b0, -1);
    run_instr("sw",     6'b101011, 6'd7, 1'b0, -1);
    run_instr("jal",    6'b000011, 6'd0, 1'b0, -1);
    run_instr("jr",     6'b000000, 6'b001000, 1'b0, -1);
    run_instr("sll",    6'b000000, 6'b000000, 1'b0, -1);
    run_instr("ori",    6'b001101, 6'd3, 1'b1, -1);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 16);
      fn  = 6'($urandom);
      case (sel)
        0, 1, 2, 3, 4, 5: begin op = 6'b000000; fn = alu_fn[sel]; end
        6:  op = 6'b001000;
        7:  op = 6'b001101;
        8:  op = 6'b000100;
        9:  op = 6'b000101;
        10: op = 6'b100011;
        11: op = 6'b101011;
        12: op = 6'b000010;
        13: op = 6'b000011;
        14: begin op = 6'b000000; fn = 6'b001000; end
        15: begin
          op = 6'($urandom_range(1, 62));
          while (kind_of(op, 6'd0) != K_NOP) op = 6'($urandom_range(1, 62));
        end
        default: begin
          op = 6'b000000;
          while (kind_of(op, fn) != K_NOP) fn = 6'($urandom);
        end
      endcase
      run_instr($sformatf("rnd%0d", i), op, fn, 1'($urandom), -1);
    end

    run_halt(20);
    run_instr("post_halt", 6'b001000, 6'd0, 1'b0, -1);
    run_instr("sw_abort",  6'b101011, 6'd0, 1'b0, 3);
    run_instr("post_abort", 6'b000000, 6'b100010, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
